// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared states and constants for the data-memory controller
package data_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_RMW_WAIT,
        ST_RMW_MERGE,
        ST_WR,
        ST_DONE
    } state_e;

    // Big-endian lane offsets: offset 0 is the most significant byte.
    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    localparam logic ACC_WORD = 1'b0;
    localparam logic ACC_BYTE = 1'b1;

    localparam logic MODE_EXTRACT = 1'b0;
    localparam logic MODE_MERGE   = 1'b1;

endpackage

// File: rtl/byte_lane_merge.sv
// rtl/byte_lane_merge.sv - big-endian byte-lane extract (load) or replace (store merge)
module byte_lane_merge
    import data_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [7:0]  byte_i,
    input  logic        mode_i,
    output logic [31:0] result_o
);

    logic [7:0]  lane;
    logic [31:0] merged;

    always_comb begin
        lane   = word_i[7:0];
        merged = word_i;
        case (offset_i)
            LANE_0: begin lane = word_i[31:24]; merged[31:24] = byte_i; end
            LANE_1: begin lane = word_i[23:16]; merged[23:16] = byte_i; end
            LANE_2: begin lane = word_i[15:8];  merged[15:8]  = byte_i; end
            LANE_3: begin lane = word_i[7:0];   merged[7:0]   = byte_i; end
            default: ;
        endcase
        result_o = (mode_i == MODE_MERGE) ? merged : {24'd0, lane};
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - CPU load/store to sync RAM controller with byte RMW; ALIGN_CHECK_EN adds misaligned-word faults
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic              cpu_byte,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_fault,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wren,
    input  logic [31:0]       ram_rdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wren_q, wren_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              fault_q, fault_d;
    logic [1:0]        off_q, off_d;
    logic [7:0]        sbyte_q, sbyte_d;
    logic              acc_q, acc_d;

    logic              misalign;
    logic [31:0]       lane_result;

`ifdef ALIGN_CHECK_EN
    assign misalign  = (cpu_byte == ACC_WORD) && (cpu_addr[1:0] != 2'b00);
    assign cpu_fault = fault_q;
`else
    assign misalign  = 1'b0;
    assign cpu_fault = 1'b0;
    logic unused_fault;
    assign unused_fault = fault_q;
`endif

    // Upper address bits are intentionally dropped, so addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[31:ADDR_W+2];

    // One lane unit serves both the load extract and the RMW merge.
    byte_lane_merge u_lane (
        .word_i   (ram_rdata),
        .offset_i (off_q),
        .byte_i   (sbyte_q),
        .mode_i   ((state_q == ST_RMW_MERGE) ? MODE_MERGE : MODE_EXTRACT),
        .result_o (lane_result)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wren_d  = 1'b0;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        fault_d = 1'b0;
        off_d   = off_q;
        sbyte_d = sbyte_q;
        acc_d   = acc_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (misalign) begin
                        ready_d = 1'b1;
                        fault_d = 1'b1;
                        rdata_d = 32'd0;
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = cpu_addr[ADDR_W+1:2];
                        off_d   = cpu_addr[1:0];
                        sbyte_d = cpu_wdata[7:0];
                        acc_d   = cpu_byte;
                        if (!cpu_wren) begin
                            state_d = ST_RD_WAIT;
                        end else if (cpu_byte == ACC_WORD) begin
                            wdata_d = cpu_wdata;
                            wren_d  = 1'b1;
                            state_d = ST_WR;
                        end else begin
                            state_d = ST_RMW_WAIT;
                        end
                    end
                end
            end
            ST_RD_WAIT:  state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                rdata_d = (acc_q == ACC_BYTE) ? lane_result : ram_rdata;
                ready_d = 1'b1;
                state_d = ST_DONE;
            end
            ST_RMW_WAIT: state_d = ST_RMW_MERGE;
            ST_RMW_MERGE: begin
                wdata_d = lane_result;
                wren_d  = 1'b1;
                state_d = ST_WR;
            end
            ST_WR: begin
                ready_d = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wren_q  <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            off_q   <= '0;
            sbyte_q <= '0;
            acc_q   <= ACC_WORD;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wren_q  <= wren_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            off_q   <= off_d;
            sbyte_q <= sbyte_d;
            acc_q   <= acc_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ready = ready_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_wren  = wren_q;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory controller directly downstream of the CPU's load/store port. It accepts one word or byte access at a time and drives a synchronous single-port RAM with a one-cycle read latency. Byte stores are done as read-modify-write. It returns load data with big-endian byte-lane selection and a one-cycle ready pulse that the CPU stalls on.

Parameters:
ADDR_W, 10, RAM word-address width; RAM depth is 2**ADDR_W words of 32 bits.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cpu_req  input  1  access request; held stable by the CPU until cpu_ready
cpu_wren  input  1  1 = store, 0 = load
cpu_byte  input  1  1 = byte access, 0 = word access
cpu_addr  input  32  byte address
cpu_wdata  input  32  store data; a byte store uses bits [7:0]
cpu_rdata  output  32  load data; valid while cpu_ready=1
cpu_ready  output  1  one-cycle completion pulse
cpu_fault  output  1  misaligned-access flag (see Optional Feature)
ram_addr  output  ADDR_W  RAM word address, registered
ram_wdata  output  32  RAM write data, registered
ram_wren  output  1  RAM write enable, registered
ram_rdata  input  32  RAM read data, valid one edge after ram_addr is sampled

Behaviour:
- Reset: asynchronous and active-high. State goes to IDLE. cpu_rdata=0, cpu_ready=0, cpu_fault=0, ram_addr=0, ram_wdata=0, ram_wren=0, all immediately. Reset mid-access abandons the access; no partial write is issued after reset.
- Word index = cpu_addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias.
- Byte lanes are big-endian: offset 00->[31:24], 01->[23:16], 10->[15:8], 11->[7:0].
- States: IDLE, RD_WAIT, RD_CAP, RMW_WAIT, RMW_MERGE, WR, DONE.
- Edge N is the edge at which cpu_req=1 is sampled in IDLE:
  - Load (word or byte): at N, ram_addr is loaded and state->RD_WAIT. At N+1, state->RD_CAP. At N+2, cpu_rdata is captured (word, or zero-extended byte lane), cpu_ready=1, state->DONE.
  - Word store: at N, ram_addr is loaded, ram_wdata=cpu_wdata, ram_wren=1, state->WR. At N+1, ram_wren=0, cpu_ready=1, state->DONE.
  - Byte store (RMW): at N, a read is issued and state->RMW_WAIT. At N+1, state->RMW_MERGE. At N+2, ram_wdata = ram_rdata with the selected lane replaced by cpu_wdata[7:0], ram_wren=1, state->WR. At N+3, ram_wren=0, cpu_ready=1, state->DONE.
- DONE: cpu_ready returns to 0 and state->IDLE on the next edge. cpu_req is not sampled in DONE, so the earliest next accept is 2 edges after the ready edge.
- Stores leave cpu_rdata unchanged.
- cpu_req=0 in IDLE: no RAM activity; ram_wren stays 0.
- While busy, cpu_req and input changes are ignored; operands are latched at edge N.
- ram_wren is high for exactly one cycle per store and never during a load.

Optional Feature:
Macro ALIGN_CHECK_EN.
- Defined: a word access with cpu_addr[1:0]!=0 issues no RAM access. At N: cpu_ready=1, cpu_fault=1, cpu_rdata=0, state->DONE. cpu_fault clears with cpu_ready.
- Not defined: cpu_fault is tied to 0, and cpu_addr[1:0] is ignored for word accesses.

Decomposition:
- Package data_mem_pkg: state enum for the seven states; lane-offset constants; word/byte access-size constant.
- One combinational sub-module, byte_lane_merge. Inputs: word, offset, byte, mode. Outputs: the merged store word, or the zero-extended extracted load byte. It is used by both the load path and the RMW path.

Test Plan:
1. Word store addr 0x0000_0010 data 0xDEADBEEF -> ram_wren=1 for one cycle with ram_addr=4; cpu_ready 1 edge later. A word load of 0x10 then returns 0xDEADBEEF with cpu_ready at N+2.
2. Byte store 0xA5 to addr 0x11 over word 0x11223344 -> RAM word becomes 0x11A53344; cpu_ready at N+3; ram_wren high exactly one cycle.
3. Byte loads of 0x10..0x13 over word 0x11A53344 -> 0x11, 0xA5, 0x33, 0x44, each zero-extended.
4. Assert rst during RMW_MERGE of a byte store -> ram_wren=0 immediately, the RAM word is unchanged, state is IDLE, and the next request is accepted normally.
5. cpu_req held continuously for back-to-back loads -> second access accepted 2 edges after the first cpu_ready; cpu_req toggled while busy -> no extra RAM access.
6. With ALIGN_CHECK_EN defined, word load addr 0x12 -> cpu_ready=1 and cpu_fault=1 at N, no ram access. Without the macro -> reads word index 4, cpu_fault=0.
